// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer and the 7-segment controller.
// Holds the FSM state encoding and the default timing constants in ms ticks.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEF_DEBOUNCE_MS    = 20;
    localparam int DEF_LONG_MS        = 1000;
    localparam int DEF_KEY_ACTIVE_LOW = 1;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for a raw button pin, normalised so o_key_act = 1 means pressed.
// Both flops reset to "not pressed" whatever the pin polarity.
module key_sync
    import key_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key,
    output logic o_key_act
);

    localparam logic INVERT = (KEY_ACTIVE_LOW != 0);

    logic key_p0;
    logic key_p1;

    // Stage 0/1: a single XOR ahead of the first flop keeps the path glitch-free
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            key_p0 <= 1'b0;
            key_p1 <= 1'b0;
        end else begin
            key_p0 <= i_key ^ INVERT;
            key_p1 <= key_p0;
        end
    end

    assign o_key_act = key_p1;

endmodule

// File: rtl/key_debounce.sv
// Debounces one push-button against the 1 ms tick and emits a clean level plus
// single-cycle press, release and long-press strobes.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS    = DEF_DEBOUNCE_MS,
    parameter int LONG_MS        = DEF_LONG_MS,
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pls_1k,
    input  logic i_key,
    output logic o_key_level,
    output logic o_press_pls,
    output logic o_release_pls,
    output logic o_long_pls
);

    localparam int DEB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int HOLD_W = $clog2(LONG_MS + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

    logic              key_act;
    key_state_t        state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;

    key_sync #(
        .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_key_sync (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_key    (i_key),
        .o_key_act(key_act)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            o_key_level   <= 1'b0;
            o_press_pls   <= 1'b0;
            o_release_pls <= 1'b0;
            o_long_pls    <= 1'b0;
        end else begin
            o_press_pls   <= 1'b0;
            o_release_pls <= 1'b0;
            o_long_pls    <= 1'b0;

            case (state)
                IDLE: begin
                    if (key_act) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end

                // A bounce back to released beats a tick in the same cycle
                PRESS_WAIT: begin
                    if (!key_act) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (i_pls_1k) begin
                        if (deb_cnt == DEB_LAST) begin
                            state       <= PRESSED;
                            hold_cnt    <= '0;
                            long_done   <= 1'b0;
                            o_press_pls <= 1'b1;
                            o_key_level <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                end

                PRESSED: begin
                    if (!key_act) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end else if (i_pls_1k && hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST && !long_done) begin
                            o_long_pls <= 1'b1;
                            long_done  <= 1'b1;
                        end
                    end
                end

                // hold_cnt and long_done are frozen so a bouncy release does not restart hold timing
                RELEASE_WAIT: begin
                    if (key_act) begin
                        state <= PRESSED;
                    end else if (i_pls_1k) begin
                        if (deb_cnt == DEB_LAST) begin
                            state         <= IDLE;
                            o_release_pls <= 1'b1;
                            o_key_level   <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: two instances (active-low and active-high pin)
// sharing clock, reset and a bench-driven 1 ms tick (one cycle in every ten).
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic i_clk    = 1'b0;
    logic i_rstn   = 1'b0;
    logic i_pls_1k = 1'b0;
    logic i_key    = 1'b1;
    logic ah_key   = 1'b0;

    logic o_key_level, o_press_pls, o_release_pls, o_long_pls;
    logic ah_level, ah_press, ah_release, ah_long;

    int passed = 0;
    int total  = 0;
    int press_cnt = 0, release_cnt = 0, long_cnt = 0;
    int ah_press_cnt = 0, ah_release_cnt = 0, overlap_cnt = 0;

    always #50 i_clk = ~i_clk;

    key_debounce #(
        .DEBOUNCE_MS   (DEB),
        .LONG_MS       (LONG),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_pls_1k     (i_pls_1k),
        .i_key        (i_key),
        .o_key_level  (o_key_level),
        .o_press_pls  (o_press_pls),
        .o_release_pls(o_release_pls),
        .o_long_pls   (o_long_pls)
    );

    key_debounce #(
        .DEBOUNCE_MS   (DEB),
        .LONG_MS       (LONG),
        .KEY_ACTIVE_LOW(0)
    ) dut_ah (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_pls_1k     (i_pls_1k),
        .i_key        (ah_key),
        .o_key_level  (ah_level),
        .o_press_pls  (ah_press),
        .o_release_pls(ah_release),
        .o_long_pls   (ah_long)
    );

    // Strobe counters sampled mid-cycle
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_press_pls)   press_cnt++;
            if (o_release_pls) release_cnt++;
            if (o_long_pls)    long_cnt++;
            if (ah_press)      ah_press_cnt++;
            if (ah_release)    ah_release_cnt++;
            if ($countones({o_press_pls, o_release_pls, o_long_pls}) > 1 ||
                $countones({ah_press, ah_release, ah_long}) > 1)
                overlap_cnt++;
        end
    end

    task automatic step(input logic p);
        i_pls_1k = p;
        @(posedge i_clk);
        #1;
    endtask

    // Nine quiet cycles then one tick; returns just after the tick edge
    task automatic period(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (9) step(1'b0);
            step(1'b1);
        end
        i_pls_1k = 1'b0;
    endtask

    task automatic clear_counts();
        press_cnt = 0; release_cnt = 0; long_cnt = 0;
        ah_press_cnt = 0; ah_release_cnt = 0;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        step(1'b0);
        step(1'b0);
        total++; if (o_key_level !== 1'b0) $display("FAIL reset_level: got %b want 0", o_key_level); else passed++;
        total++; if ({o_press_pls, o_release_pls, o_long_pls} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000", {o_press_pls, o_release_pls, o_long_pls}); else passed++;
        total++; if ({ah_level, ah_press, ah_release, ah_long} !== 4'b0000)
            $display("FAIL reset_ah_outputs: got %b want 0000", {ah_level, ah_press, ah_release, ah_long}); else passed++;
        i_rstn = 1'b1;
        repeat (5) step(1'b0);
        total++; if (o_key_level !== 1'b0) $display("FAIL idle_level: got %b want 0", o_key_level); else passed++;
        clear_counts();
    endtask

    task automatic test_clean_press();
        i_key = 1'b0;
        repeat (3) step(1'b0);
        period(3);
        total++; if ({o_press_pls, o_key_level} !== 2'b00)
            $display("FAIL clean_early: press/level got %b want 00", {o_press_pls, o_key_level}); else passed++;
        period(1);
        total++; if (o_press_pls !== 1'b1) $display("FAIL clean_press_pls: got %b want 1", o_press_pls); else passed++;
        total++; if (o_key_level !== 1'b1) $display("FAIL clean_level_rise: got %b want 1", o_key_level); else passed++;
        step(1'b0);
        total++; if ({o_press_pls, o_key_level} !== 2'b01)
            $display("FAIL clean_after: press/level got %b want 01", {o_press_pls, o_key_level}); else passed++;
        total++; if (press_cnt !== 1) $display("FAIL clean_press_count: got %0d want 1", press_cnt); else passed++;
        total++; if (release_cnt + long_cnt !== 0)
            $display("FAIL clean_other_strobes: got %0d want 0", release_cnt + long_cnt); else passed++;
    endtask

    task automatic test_long_press();
        period(LONG - 1);
        total++; if (long_cnt !== 0) $display("FAIL long_early: got %0d pulses want 0", long_cnt); else passed++;
        period(1);
        total++; if (o_long_pls !== 1'b1) $display("FAIL long_pls: got %b want 1", o_long_pls); else passed++;
        step(1'b0);
        total++; if (o_long_pls !== 1'b0) $display("FAIL long_width: got %b want 0", o_long_pls); else passed++;
        period(30);
        total++; if (long_cnt !== 1) $display("FAIL long_no_repeat: got %0d pulses want 1", long_cnt); else passed++;
        total++; if (o_key_level !== 1'b1) $display("FAIL long_level: got %b want 1", o_key_level); else passed++;
    endtask

    task automatic test_release_bounce();
        clear_counts();
        i_key = 1'b1;
        repeat (3) step(1'b0);
        period(2);
        i_key = 1'b0;
        step(1'b0);
        i_key = 1'b1;
        repeat (4) step(1'b0);
        period(3);
        total++; if ({o_release_pls, o_key_level} !== 2'b01)
            $display("FAIL release_early: release/level got %b want 01", {o_release_pls, o_key_level}); else passed++;
        period(1);
        total++; if ({o_release_pls, o_key_level} !== 2'b10)
            $display("FAIL release_pls: release/level got %b want 10", {o_release_pls, o_key_level}); else passed++;
        step(1'b0);
        total++; if (o_release_pls !== 1'b0) $display("FAIL release_width: got %b want 0", o_release_pls); else passed++;
        total++; if (release_cnt !== 1) $display("FAIL release_count: got %0d want 1", release_cnt); else passed++;
        total++; if (press_cnt + long_cnt !== 0)
            $display("FAIL release_other_strobes: got %0d want 0", press_cnt + long_cnt); else passed++;
    endtask

    task automatic test_press_bounce();
        clear_counts();
        i_key = 1'b0;
        repeat (3) step(1'b0);
        period(2);
        i_key = 1'b1;
        step(1'b0);
        i_key = 1'b0;
        repeat (4) step(1'b0);
        period(3);
        total++; if (press_cnt !== 0) $display("FAIL bounce_early: got %0d press pulses want 0", press_cnt); else passed++;
        period(1);
        total++; if ({o_press_pls, o_key_level} !== 2'b11)
            $display("FAIL bounce_press: press/level got %b want 11", {o_press_pls, o_key_level}); else passed++;
        step(1'b0);
        total++; if (press_cnt !== 1) $display("FAIL bounce_count: got %0d want 1", press_cnt); else passed++;
    endtask

    task automatic test_reset_mid_press();
        clear_counts();
        total++; if (o_key_level !== 1'b1) $display("FAIL midrst_pre_level: got %b want 1", o_key_level); else passed++;
        #20;
        i_rstn = 1'b0;
        #1;
        total++; if ({o_key_level, o_press_pls, o_release_pls, o_long_pls} !== 4'b0000)
            $display("FAIL midrst_async: got %b want 0000", {o_key_level, o_press_pls, o_release_pls, o_long_pls}); else passed++;
        @(posedge i_clk);
        #1;
        step(1'b0);
        step(1'b0);
        i_rstn = 1'b1;
        repeat (3) step(1'b0);
        period(3);
        total++; if ({o_press_pls, o_key_level} !== 2'b00)
            $display("FAIL midrst_early: press/level got %b want 00", {o_press_pls, o_key_level}); else passed++;
        period(1);
        total++; if ({o_press_pls, o_key_level} !== 2'b11)
            $display("FAIL midrst_repress: press/level got %b want 11", {o_press_pls, o_key_level}); else passed++;
        step(1'b0);
        total++; if (press_cnt !== 1) $display("FAIL midrst_press_count: got %0d want 1", press_cnt); else passed++;
        total++; if (release_cnt !== 0) $display("FAIL midrst_no_release: got %0d want 0", release_cnt); else passed++;
    endtask

    task automatic test_polarity();
        clear_counts();
        ah_key = 1'b1;
        repeat (3) step(1'b0);
        period(3);
        total++; if ({ah_press, ah_level} !== 2'b00)
            $display("FAIL ah_early: press/level got %b want 00", {ah_press, ah_level}); else passed++;
        period(1);
        total++; if ({ah_press, ah_level} !== 2'b11)
            $display("FAIL ah_press: press/level got %b want 11", {ah_press, ah_level}); else passed++;
        step(1'b0);
        total++; if ({ah_press, ah_level} !== 2'b01)
            $display("FAIL ah_after: press/level got %b want 01", {ah_press, ah_level}); else passed++;
        total++; if (ah_press_cnt !== 1 || ah_release_cnt !== 0)
            $display("FAIL ah_counts: press %0d release %0d want 1 0", ah_press_cnt, ah_release_cnt); else passed++;
    endtask

    task automatic test_exclusive();
        total++; if (overlap_cnt !== 0) $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_long_press();
        test_release_bounce();
        test_press_bounce();
        test_reset_mid_press();
        test_polarity();
        test_exclusive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Consumer side of the 1 kHz tick interface: takes the single-cycle 1 ms strobe from the tick generator and debounces one mechanical push-button.
- Emits a clean level plus single-cycle press, release and long-press strobes for the key/7-segment control logic.
- Runs on the 10 MHz system clock (100 ns); all timing is counted in ticks, never in raw clock cycles.

Parameters:
- DEBOUNCE_MS, 20, number of consecutive stable ticks required to accept a press or a release; legal range 1..255.
- LONG_MS, 1000, ticks held in PRESSED before o_long_pls fires; must be greater than DEBOUNCE_MS.
- KEY_ACTIVE_LOW, 1, 1 = pressed key drives i_key low; 0 = pressed drives high.

Ports:
- i_clk  input  1  system clock, 10 MHz
- i_rstn  input  1  asynchronous active-low reset
- i_pls_1k  input  1  1 ms tick, high for exactly one i_clk cycle per period
- i_key  input  1  raw asynchronous button pin
- o_key_level  output  1  debounced key state, 1 = pressed
- o_press_pls  output  1  one-cycle strobe on accepted press
- o_release_pls  output  1  one-cycle strobe on accepted release
- o_long_pls  output  1  one-cycle strobe when the hold reaches LONG_MS

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low on i_rstn.
- Reset state: all outputs 0, synchronizer flops 0 after polarity normalisation (i.e. "not pressed"), state IDLE, counters 0, long_done 0.
- Input path: i_key passes through a 2-flop synchronizer. It is then normalised to key_act (1 = pressed) per KEY_ACTIVE_LOW. Two cycles of latency before the FSM sees a change.
- Counters:
  - deb_cnt, width $clog2(DEBOUNCE_MS+1).
  - hold_cnt, width $clog2(LONG_MS+1), saturating at LONG_MS.
  - Both increment only on cycles with i_pls_1k=1.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - key_act=1 -> PRESS_WAIT, deb_cnt=0.
- PRESS_WAIT:
  - key_act=0 in any cycle -> IDLE, deb_cnt=0. Bounce wins over a simultaneous tick.
  - key_act=1 and tick: if deb_cnt==DEBOUNCE_MS-1 -> PRESSED, hold_cnt=0, long_done=0, o_press_pls=1 for that next cycle only. Otherwise deb_cnt+1.
- PRESSED:
  - On tick, hold_cnt+1 until it saturates.
  - When hold_cnt reaches LONG_MS and long_done=0: o_long_pls=1 for one cycle, long_done=1. No repeat.
  - key_act=0 -> RELEASE_WAIT, deb_cnt=0.
- RELEASE_WAIT:
  - key_act=1 -> PRESSED, with hold_cnt and long_done unchanged. Hold timing continues across release bounce; hold_cnt does not advance while in RELEASE_WAIT.
  - key_act=0 and tick with deb_cnt==DEBOUNCE_MS-1 -> IDLE, o_release_pls=1 for one cycle.
- Output timing: o_key_level is registered; it is 1 in PRESSED and RELEASE_WAIT and 0 otherwise. It rises in the same cycle o_press_pls is high and falls in the same cycle o_release_pls is high.
- Strobe exclusivity: press, release and long strobes are mutually exclusive in any cycle.
- Debounce latency: press acceptance takes DEBOUNCE_MS ticks from the first tick seen with key_act stable. This is between DEBOUNCE_MS-1 and DEBOUNCE_MS ms after the pin settles, plus 2-3 clocks.
- Tick edge cases:
  - A tick arriving in the same cycle as IDLE->PRESS_WAIT is not counted.
  - i_pls_1k stuck at 1 is out of spec; the counters then count per clock, with no other hazard.
- Reset mid-press: the FSM returns to IDLE immediately with all outputs low. No release strobe is generated. A key still held after reset is re-debounced and produces a fresh o_press_pls.

Decomposition:
- Package key_pkg:
  - FSM state encoding (2-bit localparams IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3).
  - Default DEBOUNCE_MS/LONG_MS constants shared with the 7-seg controller.
- Sub-module key_sync: 2-flop synchronizer plus polarity normalisation, with ports i_clk, i_rstn, i_key, o_key_act. It is reused by the multi-key wrapper.

Test Plan:
- Bench settings: DEBOUNCE_MS=4, LONG_MS=10, KEY_ACTIVE_LOW=1. The bench drives i_pls_1k one cycle in every 10.
- Clean press: i_key 1->0 and held -> o_press_pls high exactly 1 cycle after the 4th counted tick; o_key_level=1 from that cycle; no other strobes.
- Press bounce: i_key low for 2 ticks, high for 1 cycle, then low and held -> no press strobe before 4 further ticks; exactly one o_press_pls total.
- Long press: held 4+10 ticks -> o_long_pls exactly once at the 10th tick after entry to PRESSED. Holding 30 more ticks -> no second pulse.
- Release with bounce: while held, i_key high for 2 ticks, low 1 cycle, high and held -> o_release_pls once after 4 stable ticks. o_key_level stays 1 until that cycle. A long press already fired stays non-repeated.
- Reset mid-press: assert i_rstn=0 in PRESSED -> o_key_level, all strobes 0 asynchronously. Release reset with key held -> new o_press_pls after 4 ticks; no release strobe.
- Polarity: KEY_ACTIVE_LOW=0, i_key 0->1 held -> press strobe after 4 ticks, identical timing to the clean-press case.
